// File: rtl/intt4point_seq_if.sv
// Handshake bundle for intt4point_seq: input vector, result vector and busy status.
// master = producer/consumer side, slave = the transform block.
interface intt4point_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in0, in1, in2, in3;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out0, out1, out2, out3;
    logic        busy;

    modport master (
        output in_valid, in0, in1, in2, in3, out_ready,
        input  in_ready, out_valid, out0, out1, out2, out3, busy
    );

    modport slave (
        input  in_valid, in0, in1, in2, in3, out_ready,
        output in_ready, out_valid, out0, out1, out2, out3, busy
    );
endinterface

// File: rtl/intt4point_seq.sv
// Sequential 4-point inverse negacyclic NTT over Z_7681 using one shared GS butterfly.
// Define INTT_NINV_SCALE_EN to include the final 4^-1 scaling pass (SC0..SC3).
module intt4point_seq #(
    parameter int Q        = 7681,
    parameter int PSI_INV1 = 1213,
    parameter int PSI_INV2 = 4298,
    parameter int PSI_INV3 = 5756,
    parameter int N_INV    = 5761
) (
    input logic              clk,
    input logic              rst,
    intt4point_seq_if.slave  io
);

    typedef enum logic [3:0] {
        IDLE, S1A, S1B, S2A, S2B, SC0, SC1, SC2, SC3, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] b_q   [4];
    logic [15:0] b_d   [4];
    logic [15:0] out_q [4];
    logic [15:0] out_d [4];
    logic        out_valid_q, out_valid_d;

    logic [1:0]  ix, iy;
    logic [15:0] w;
    logic        scale_op;
    logic [15:0] x, y, sum, diff, mul_a, red;
    logic [16:0] sum_raw;
    logic [31:0] prod;

    // Operand routing for the shared butterfly / multiplier
    always_comb begin
        ix       = 2'd0;
        iy       = 2'd1;
        w        = 16'(PSI_INV1);
        scale_op = 1'b0;
        case (state_q)
            S1B: begin ix = 2'd2; iy = 2'd3; w = 16'(PSI_INV3); end
            S2A: begin ix = 2'd0; iy = 2'd2; w = 16'(PSI_INV2); end
            S2B: begin ix = 2'd1; iy = 2'd3; w = 16'(PSI_INV2); end
            SC0: begin ix = 2'd0; scale_op = 1'b1; w = 16'(N_INV); end
            SC1: begin ix = 2'd1; scale_op = 1'b1; w = 16'(N_INV); end
            SC2: begin ix = 2'd2; scale_op = 1'b1; w = 16'(N_INV); end
            SC3: begin ix = 2'd3; scale_op = 1'b1; w = 16'(N_INV); end
            default: ;
        endcase
    end

    always_comb begin
        x       = b_q[ix];
        y       = b_q[iy];
        sum_raw = {1'b0, x} + {1'b0, y};
        sum     = (sum_raw >= 17'(Q)) ? 16'(sum_raw - 17'(Q)) : 16'(sum_raw);
        diff    = (x >= y) ? (x - y) : (x + 16'(Q) - y);
        mul_a   = scale_op ? x : diff;
        prod    = {16'd0, mul_a} * {16'd0, w};
        red     = 16'(prod % 32'(Q));
    end

    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    // bit-reversed load feeds the GS network natural-order input
                    b_d[0]  = io.in0;
                    b_d[1]  = io.in2;
                    b_d[2]  = io.in1;
                    b_d[3]  = io.in3;
                    state_d = S1A;
                end
            end
            S1A, S1B, S2A, S2B: begin
                b_d[ix] = sum;
                b_d[iy] = red;
                case (state_q)
                    S1A:     state_d = S1B;
                    S1B:     state_d = S2A;
                    S2A:     state_d = S2B;
`ifdef INTT_NINV_SCALE_EN
                    default: state_d = SC0;
`else
                    default: state_d = DONE;
`endif
                endcase
            end
`ifdef INTT_NINV_SCALE_EN
            SC0: begin b_d[ix] = red; state_d = SC1;  end
            SC1: begin b_d[ix] = red; state_d = SC2;  end
            SC2: begin b_d[ix] = red; state_d = SC3;  end
            SC3: begin b_d[ix] = red; state_d = DONE; end
`endif
            DONE: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Result registers capture the final buffer on the edge that enters DONE
        if (state_d == DONE && state_q != DONE) begin
            out_d       = b_d;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                b_q[k]   <= 16'd0;
                out_q[k] <= 16'd0;
            end
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            b_q         <= b_d;
            out_q       <= out_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.busy      = (state_q != IDLE);
    assign io.out_valid = out_valid_q;
    assign io.out0      = out_q[0];
    assign io.out1      = out_q[1];
    assign io.out2      = out_q[2];
    assign io.out3      = out_q[3];

endmodule

// File: tb/tb_intt4point_seq.sv
// Self-checking bench for intt4point_seq: direct inverse-transform model plus
// round trips through a forward-NTT model, handshake, reset and throughput checks.
module tb_intt4point_seq;
    localparam int Q = 7681;
`ifdef INTT_NINV_SCALE_EN
    localparam bit SCALE = 1'b1;
`else
    localparam bit SCALE = 1'b0;
`endif
    localparam int LAT = SCALE ? 8 : 4;
    localparam int II  = LAT + 2;

    typedef logic [3:0][15:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    intt4point_seq_if io();
    intt4point_seq dut (.clk(clk), .rst(rst), .io(io));

    int   n_vec = 0, n_cmp = 0, n_err = 0, cyc = 0;
    vec_t exp_q[$];
    int   acc_q[$];
    bit   prev_ov = 1'b0, b2b = 1'b0, have_prev = 1'b0;
    int   last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint pw(longint b, int e);
        longint r = 1;
        for (int k = 0; k < e; k++) r = (r * b) % Q;
        return r;
    endfunction

    function automatic vec_t mk(int a0, int a1, int a2, int a3);
        vec_t v;
        v[0] = 16'(a0); v[1] = 16'(a1); v[2] = 16'(a2); v[3] = 16'(a3);
        return v;
    endfunction

    // A_j = sum_i a_i * psi^((2j+1)i)
    function automatic vec_t fwd(vec_t a);
        vec_t r;
        for (int j = 0; j < 4; j++) begin
            longint s = 0;
            for (int i = 0; i < 4; i++)
                s = (s + longint'(a[i]) * pw(1925, ((2*j+1)*i) % 8)) % Q;
            r[j] = 16'(s);
        end
        return r;
    endfunction

    // 4*a_i = sum_j A_j * psi^-((2j+1)i); scaled by 4^-1 when the scale pass exists
    function automatic vec_t inv(vec_t A);
        vec_t r;
        for (int i = 0; i < 4; i++) begin
            longint s = 0;
            for (int j = 0; j < 4; j++)
                s = (s + longint'(A[j]) * pw(1213, ((2*j+1)*i) % 8)) % Q;
            if (SCALE) s = (s * 5761) % Q;
            r[i] = 16'(s);
        end
        return r;
    endfunction

    function automatic vec_t scl(vec_t a);
        vec_t r;
        for (int i = 0; i < 4; i++)
            r[i] = SCALE ? a[i] : 16'((longint'(a[i]) * 4) % Q);
        return r;
    endfunction

    function automatic vec_t outs();
        return {io.out3, io.out2, io.out1, io.out0};
    endfunction

    function automatic vec_t ins();
        return {io.in3, io.in2, io.in1, io.in0};
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_vec(string nm, vec_t act, vec_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {%0d,%0d,%0d,%0d} expected {%0d,%0d,%0d,%0d} (t=%0t)",
                     nm, act[0], act[1], act[2], act[3], exp[0], exp[1], exp[2], exp[3], $time);
        end
    endtask

    // Compare process: tracks accepts and checks every valid output cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (io.in_valid && io.in_ready) begin
                exp_q.push_back(inv(ins()));
                acc_q.push_back(cyc + 1);
                n_vec++;
                if (b2b) begin
                    if (have_prev) chk("accept_interval", cyc + 1 - last_acc, II);
                    last_acc  = cyc + 1;
                    have_prev = 1'b1;
                end
            end
            if (io.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    chk_vec("model_out", outs(), exp_q[0]);
                    if (!prev_ov) chk("model_latency", cyc - acc_q[0], LAT);
                    chk("in_ready_in_done", io.in_ready, 0);
                    chk("busy_in_done", io.busy, 1);
                    if (io.out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            prev_ov = io.out_valid;
        end
    end

    task automatic put(vec_t v, bit keep);
        int t = 0;
        io.in_valid = 1'b1;
        io.in0 = v[0]; io.in1 = v[1]; io.in2 = v[2]; io.in3 = v[3];
        while (!io.in_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 100) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (!keep) io.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!io.out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 200) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic get(vec_t exp, string nm, output int lat);
        wait_valid(lat);
        chk_vec(nm, outs(), exp);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t a, a2;
        int   lat;
        io.in_valid = 1'b0; io.out_ready = 1'b1;
        io.in0 = '0; io.in1 = '0; io.in2 = '0; io.in3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", io.in_ready, 1);
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_busy", io.busy, 0);
        chk_vec("rst_outs", outs(), mk(0, 0, 0, 0));
        rst = 1'b0;

        put(mk(1, 1, 1, 1), 1'b0);
        get(SCALE ? mk(1, 0, 0, 0) : mk(4, 0, 0, 0), "impulse", lat);
        chk("impulse_latency", lat, LAT);

        put(mk(1925, 6468, 5756, 1213), 1'b0);
        get(SCALE ? mk(0, 1, 0, 0) : mk(0, 4, 0, 0), "shifted_impulse", lat);

        for (int n = 0; n < 202; n++) begin
            if (n == 0)      a = mk(0, 0, 0, 0);
            else if (n == 1) a = mk(Q-1, Q-1, Q-1, Q-1);
            else a = mk($urandom_range(Q-1, 0), $urandom_range(Q-1, 0),
                        $urandom_range(Q-1, 0), $urandom_range(Q-1, 0));
            put(fwd(a), 1'b0);
            get(scl(a), "round_trip", lat);
        end

        // Back-pressure: result held for 5 cycles, second vector waits
        a  = mk($urandom_range(Q-1, 0), 17, 0, Q-1);
        a2 = mk(3, $urandom_range(Q-1, 0), 2000, 1);
        io.out_ready = 1'b0;
        put(fwd(a), 1'b0);
        wait_valid(lat);
        put_hold(fwd(a2));
        repeat (5) begin
            @(posedge clk); #1;
            chk_vec("bp_hold", outs(), scl(a));
            chk("bp_out_valid", io.out_valid, 1);
            chk("bp_in_ready", io.in_ready, 0);
        end
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", io.in_ready, 1);
        chk("bp_release_out_valid", io.out_valid, 0);
        chk("bp_release_busy", io.busy, 0);
        chk_vec("bp_outs_retained", outs(), scl(a));
        @(posedge clk); #1;
        chk("bp_second_accepted", io.busy, 1);
        io.in_valid = 1'b0;
        get(scl(a2), "bp_second", lat);

        // Reset while in S2A
        a = mk(5, 6, 7, 8);
        put(fwd(a), 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", io.in_ready, 1);
        chk("midrst_out_valid", io.out_valid, 0);
        chk("midrst_busy", io.busy, 0);
        chk_vec("midrst_outs", outs(), mk(0, 0, 0, 0));
        rst = 1'b0;
        a = mk(Q-1, 0, 1, 4000);
        put(fwd(a), 1'b0);
        get(scl(a), "after_reset", lat);

        // Back-to-back with in_valid held and out_ready tied high
        b2b = 1'b1; have_prev = 1'b0;
        put(fwd(mk(1, 2, 3, 4)), 1'b1);
        put(fwd(mk(7680, 7679, 100, 0)), 1'b1);
        put(fwd(mk($urandom_range(Q-1, 0), 9, 99, 999)), 1'b0);
        lat = 0;
        while (exp_q.size() != 0 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 100) chk("b2b_drain_timeout", 0, 1);
        b2b = 1'b0;

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    task automatic put_hold(vec_t v);
        io.in_valid = 1'b1;
        io.in0 = v[0]; io.in1 = v[1]; io.in2 = v[2]; io.in3 = v[3];
    endtask

endmodule
